// File: rtl/dqsw_train_pkg.sv
// dqsw_train_pkg
// Shared definitions for the DQSW write-DQS edge trainer:
//   - train_state_e : trainer FSM state encoding
//   - Def*          : default parameter values for dqsw_edge_trainer
//   - max_u         : unsigned maximum, used to size the shared wait timer
//   - cnt_width     : counter width able to hold values 0..n-1 (at least 1 bit)
package dqsw_train_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StClear,
    StSettle,
    StSample,
    StStep,
    StBackoff,
    StDone,
    StFail
  } train_state_e;

  localparam int unsigned DefMaxTaps      = 128;
  localparam int unsigned DefTapW         = 8;
  localparam int unsigned DefSettleCycles = 8;
  localparam int unsigned DefSampleCycles = 16;
  localparam int unsigned DefBackoffTaps  = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dqsw_train_timer.sv
// dqsw_train_timer
// Loadable down-counter with a terminal-count strobe. The trainer loads it on entry to SETTLE
// and SAMPLE with (cycles - 1); tc_o is high in the last cycle of the window.
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous reset, active-low
//   load_i     : load load_val_i into the counter (takes priority over en_i)
//   load_val_i : value to load
//   en_i       : decrement by one (saturates at zero)
//   tc_o       : counter is zero
module dqsw_train_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  localparam logic [Width-1:0] CntOne = Width'(1);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/dqsw_edge_trainer.sv
// dqsw_edge_trainer
// Write-DQS edge training controller for one lane's DQSW IOD. On START it reloads the delay
// line to tap 0, then repeats clear / settle / sample over the eye-monitor flags, stepping one
// tap forward per iteration until EARLY or LATE is seen inside a sample window. The hit tap is
// latched in EDGE_TAP, the line is backed off by up to BACKOFF_TAPS taps and DONE is raised.
// Sweeping past tap MAX_TAPS-1 or an IOD out-of-range indication raises FAIL.
// Ports:
//   FAB_CLK, ARST_N                : clock and asynchronous active-low reset
//   START, ABORT                   : training request / cancel (ABORT has priority)
//   DELAY_LINE_LOAD/MOVE/DIRECTION : delay-line control pulses to the IOD
//   EYE_MONITOR_CLEAR_FLAGS        : eye-monitor flag clear pulse to the IOD
//   DELAY_LINE_OUT_OF_RANGE        : fatal range indication from the IOD
//   EYE_MONITOR_EARLY/LATE         : eye-monitor flags from the IOD
//   BUSY, DONE, FAIL               : status (DONE/FAIL sticky until START or ABORT)
//   EDGE_TAP, CUR_TAP              : detected edge tap and tracked current tap
// All outputs are registered and derived from the next state.
module dqsw_edge_trainer
  import dqsw_train_pkg::*;
#(
  parameter int unsigned MAX_TAPS      = DefMaxTaps,
  parameter int unsigned TAP_W         = DefTapW,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned SAMPLE_CYCLES = DefSampleCycles,
  parameter int unsigned BACKOFF_TAPS  = DefBackoffTaps
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             START,
  input  logic             ABORT,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [TAP_W-1:0] EDGE_TAP,
  output logic [TAP_W-1:0] CUR_TAP
);

  localparam int unsigned WaitMax = max_u(SETTLE_CYCLES, SAMPLE_CYCLES);
  localparam int unsigned CntW    = cnt_width(WaitMax);

  localparam logic [TAP_W-1:0] LastTap    = TAP_W'(MAX_TAPS - 1);
  localparam logic [TAP_W-1:0] TapOne     = TAP_W'(1);
  localparam logic [CntW-1:0]  SettleLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0]  SampleLoad = CntW'(SAMPLE_CYCLES - 1);

  train_state_e     state_d, state_q;
  logic             gap_d, gap_q;          // second cycle of a STEP/BACKOFF move (MOVE low)
  logic             hit_d, hit_q;          // any flag seen in the current sample window
  logic [TAP_W-1:0] cur_tap_d, cur_tap_q;
  logic [TAP_W-1:0] edge_tap_d, edge_tap_q;
  logic [TAP_W-1:0] bo_left_d, bo_left_q;  // decrement pulses still to issue after this one

  logic load_d, load_q;
  logic clear_d, clear_q;
  logic move_d, move_q;
  logic dir_d, dir_q;
  logic busy_d, busy_q;
  logic done_d, done_q;
  logic fail_d, fail_q;

  logic             tmr_load;
  logic [CntW-1:0]  tmr_val;
  logic             tmr_en;
  logic             tmr_tc;
  logic             flag_in;
  logic [TAP_W-1:0] bo_total;

  assign flag_in = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;

  // Back-off is clamped to the edge tap so the tracked tap can never go below zero.
  assign bo_total = (32'(cur_tap_q) < BACKOFF_TAPS) ? cur_tap_q : TAP_W'(BACKOFF_TAPS);

  dqsw_train_timer #(
    .Width (CntW)
  ) u_timer (
    .clk_i      (FAB_CLK),
    .rst_ni     (ARST_N),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    gap_d      = 1'b0;
    hit_d      = hit_q;
    cur_tap_d  = cur_tap_q;
    edge_tap_d = edge_tap_q;
    bo_left_d  = bo_left_q;
    tmr_load   = 1'b0;
    tmr_val    = SettleLoad;
    tmr_en     = 1'b0;

    if (ABORT) begin
      state_d = StIdle;
    end else if (busy_q && DELAY_LINE_OUT_OF_RANGE) begin
      state_d = StFail;
    end else begin
      case (state_q)
        StIdle, StDone, StFail: begin
          if (START) begin
            state_d   = StLoad;
            cur_tap_d = '0;
          end
        end
        StLoad: begin
          state_d = StClear;
        end
        StClear: begin
          hit_d    = 1'b0;
          state_d  = StSettle;
          tmr_load = 1'b1;
          tmr_val  = SettleLoad;
        end
        StSettle: begin
          if (tmr_tc) begin
            state_d  = StSample;
            tmr_load = 1'b1;
            tmr_val  = SampleLoad;
          end else begin
            tmr_en = 1'b1;
          end
        end
        StSample: begin
          hit_d = hit_q | flag_in;
          if (!tmr_tc) begin
            tmr_en = 1'b1;
          end else if (hit_d) begin
            edge_tap_d = cur_tap_q;
            if (bo_total == '0) begin
              state_d = StDone;
            end else begin
              state_d   = StBackoff;
              cur_tap_d = cur_tap_q - TapOne;
              bo_left_d = bo_total - TapOne;
            end
          end else if (cur_tap_q == LastTap) begin
            state_d = StFail;
          end else begin
            state_d   = StStep;
            cur_tap_d = cur_tap_q + TapOne;
          end
        end
        StStep: begin
          if (!gap_q) begin
            gap_d = 1'b1;
          end else begin
            state_d = StClear;
          end
        end
        StBackoff: begin
          if (!gap_q) begin
            gap_d = 1'b1;
          end else if (bo_left_q == '0) begin
            state_d = StDone;
          end else begin
            cur_tap_d = cur_tap_q - TapOne;
            bo_left_d = bo_left_q - TapOne;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    load_d  = (state_d == StLoad);
    clear_d = (state_d == StClear);
    move_d  = ((state_d == StStep) || (state_d == StBackoff)) && !gap_d;
    dir_d   = (state_d == StStep);
    busy_d  = !(state_d inside {StIdle, StDone, StFail});
    done_d  = (state_d == StDone);
    fail_d  = (state_d == StFail);
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q    <= StIdle;
      gap_q      <= 1'b0;
      hit_q      <= 1'b0;
      cur_tap_q  <= '0;
      edge_tap_q <= '0;
      bo_left_q  <= '0;
      load_q     <= 1'b0;
      clear_q    <= 1'b0;
      move_q     <= 1'b0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      hit_q      <= hit_d;
      cur_tap_q  <= cur_tap_d;
      edge_tap_q <= edge_tap_d;
      bo_left_q  <= bo_left_d;
      load_q     <= load_d;
      clear_q    <= clear_d;
      move_q     <= move_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
  assign FAIL                    = fail_q;
  assign EDGE_TAP                = edge_tap_q;
  assign CUR_TAP                 = cur_tap_q;

endmodule

// File: tb/tb_dqsw_edge_trainer.sv
// tb_dqsw_edge_trainer
// Drives the trainer against a behavioural IOD: a delay line that follows LOAD/MOVE pulses and
// an eye monitor whose flags depend on the IOD's tap. Expected results (edge tap, pulse counts,
// final tap, completion cycle) come from the training rules with plain arithmetic.
module tb_dqsw_edge_trainer;

  localparam int MaxTaps = 128;
  localparam int TapW    = 8;
  localparam int Settle  = 8;
  localparam int Sample  = 16;
  localparam int Backoff = 4;
  localparam int First   = 2 + Settle + Sample;      // last cycle of the first sample window
  localparam int Iter    = 2 + 1 + Settle + Sample;  // cycles per extra tap

  localparam int ModeLevel  = 1;  // EARLY high while tap >= e
  localparam int ModePulse  = 2;  // LATE high one cycle inside SAMPLE at tap e
  localparam int ModeSettle = 3;  // EARLY only during SETTLE at tap fs, plus level edge at e

  logic            FAB_CLK;
  logic            ARST_N;
  logic            START;
  logic            ABORT;
  logic            DELAY_LINE_LOAD;
  logic            DELAY_LINE_MOVE;
  logic            DELAY_LINE_DIRECTION;
  logic            EYE_MONITOR_CLEAR_FLAGS;
  logic            DELAY_LINE_OUT_OF_RANGE;
  logic            EYE_MONITOR_EARLY;
  logic            EYE_MONITOR_LATE;
  logic            BUSY;
  logic            DONE;
  logic            FAIL;
  logic [TapW-1:0] EDGE_TAP;
  logic [TapW-1:0] CUR_TAP;

  int n_checks = 0;
  int n_errors = 0;
  int iod_tap  = 0;

  dqsw_edge_trainer #(
    .MAX_TAPS      (MaxTaps),
    .TAP_W         (TapW),
    .SETTLE_CYCLES (Settle),
    .SAMPLE_CYCLES (Sample),
    .BACKOFF_TAPS  (Backoff)
  ) dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .START                   (START),
    .ABORT                   (ABORT),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .EYE_MONITOR_EARLY       (EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE        (EYE_MONITOR_LATE),
    .BUSY                    (BUSY),
    .DONE                    (DONE),
    .FAIL                    (FAIL),
    .EDGE_TAP                (EDGE_TAP),
    .CUR_TAP                 (CUR_TAP)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called one step after a rising edge; that cycle is cycle 0 with START high.
  task automatic train_and_check(input string name, input int mode, input int e, input int fs,
                                 input int oor_tap, input int abort_tap, input int spur_at);
    int  since_clear = 1000;
    int  k = 0;
    int  off;
    int  b = 0;
    int  exp_end = 0;
    int  exp_inc = 0;
    int  exp_dec = 0;
    int  exp_cur = 0;
    bit  exp_done = 1'b0;
    int  oor_cyc = -1;
    int  abort_cyc = -1;
    int  end_cyc = -1;
    int  stop_cyc;
    int  n_inc = 0;
    int  n_dec = 0;
    int  gap_err = 0;
    int  stray_load = 0;
    int  move_post = 0;
    bit  ended = 1'b0;
    bit  prev_move = 1'b0;
    bit  in_settle;

    off = $urandom_range(Sample - 1, 0);
    if (oor_tap >= 0) begin
      exp_inc = oor_tap;
      exp_cur = oor_tap;
    end else if (e >= 0) begin
      b        = (e < Backoff) ? e : Backoff;
      exp_inc  = e;
      exp_dec  = b;
      exp_cur  = e - b;
      exp_done = 1'b1;
      exp_end  = First + Iter * e + 2 * b + 1;
    end else begin
      exp_inc = MaxTaps - 1;
      exp_cur = MaxTaps - 1;
      exp_end = First + Iter * (MaxTaps - 1) + 1;
    end
    stop_cyc = First + Iter * MaxTaps + 40;

    START = 1'b1;
    while (k < stop_cyc) begin
      @(posedge FAB_CLK);
      #1;
      k++;
      START = 1'b0;
      ABORT = 1'b0;
      DELAY_LINE_OUT_OF_RANGE = 1'b0;

      if (k == 1) begin
        check_eq({name, "/load_after_start"}, 32'(DELAY_LINE_LOAD), 1);
        check_eq({name, "/done_cleared"}, 32'(DONE), 0);
        check_eq({name, "/fail_cleared"}, 32'(FAIL), 0);
      end

      // Behavioural IOD delay line.
      if (DELAY_LINE_LOAD) begin
        if (k != 1) stray_load++;
        iod_tap = 0;
      end
      if (DELAY_LINE_MOVE) begin
        if (prev_move) gap_err++;
        if (ended) move_post++;
        if (DELAY_LINE_DIRECTION) begin
          n_inc++;
          iod_tap++;
        end else begin
          n_dec++;
          iod_tap--;
        end
      end
      prev_move   = DELAY_LINE_MOVE;
      since_clear = EYE_MONITOR_CLEAR_FLAGS ? 0 : since_clear + 1;

      if (abort_cyc >= 0 && k == abort_cyc + 1) begin
        check_eq({name, "/abort_outputs_low"},
                 32'({DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_MOVE,
                      DELAY_LINE_DIRECTION, BUSY, DONE, FAIL}), 0);
        ended    = 1'b1;
        end_cyc  = k;
        stop_cyc = k + 6;
      end
      if (!ended && (DONE || FAIL)) begin
        ended    = 1'b1;
        end_cyc  = k;
        stop_cyc = k + 6;
      end

      // Behavioural eye monitor: flags for this cycle.
      EYE_MONITOR_EARLY = 1'b0;
      EYE_MONITOR_LATE  = 1'b0;
      if (!ended) begin
        in_settle = (since_clear >= 1) && (since_clear <= Settle);
        EYE_MONITOR_EARLY = ((mode == ModeLevel || mode == ModeSettle) && e >= 0 && iod_tap >= e)
                         || (mode == ModeSettle && in_settle && iod_tap == fs);
        EYE_MONITOR_LATE  = (mode == ModePulse) && e >= 0 && iod_tap == e
                         && since_clear == Settle + 1 + off;
        if (k == spur_at) START = 1'b1;
        if (oor_tap >= 0 && oor_cyc < 0 && iod_tap == oor_tap && since_clear == Settle + 1) begin
          DELAY_LINE_OUT_OF_RANGE = 1'b1;
          oor_cyc = k;
        end
        if (abort_tap >= 0 && abort_cyc < 0 && iod_tap == abort_tap
            && since_clear == Settle + 3) begin
          ABORT = 1'b1;
          abort_cyc = k;
        end
      end
    end

    check_eq({name, "/finished_in_budget"}, 32'(ended), 1);
    check_eq({name, "/no_stray_load"}, stray_load, 0);
    check_eq({name, "/move_gap"}, gap_err, 0);
    check_eq({name, "/no_move_after_end"}, move_post, 0);
    check_eq({name, "/busy_low"}, 32'(BUSY), 0);
    check_eq({name, "/iod_tracks_cur_tap"}, 32'(CUR_TAP), iod_tap);
    if (abort_tap < 0) begin
      check_eq({name, "/done"}, 32'(DONE), 32'(exp_done));
      check_eq({name, "/fail"}, 32'(FAIL), 32'(!exp_done));
      check_eq({name, "/cur_tap"}, 32'(CUR_TAP), exp_cur);
      check_eq({name, "/inc_pulses"}, n_inc, exp_inc);
      check_eq({name, "/dec_pulses"}, n_dec, exp_dec);
      if (oor_tap >= 0) begin
        check_eq({name, "/fail_one_cycle_after_oor"}, end_cyc, oor_cyc + 1);
      end else begin
        check_eq({name, "/end_cycle"}, end_cyc, exp_end);
      end
      if (exp_done) check_eq({name, "/edge_tap"}, 32'(EDGE_TAP), e);
    end
  endtask

  initial begin
    int mode;
    int e;
    int fs;

    ARST_N = 1'b0;
    START = 1'b0;
    ABORT = 1'b0;
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    EYE_MONITOR_EARLY = 1'b0;
    EYE_MONITOR_LATE = 1'b0;

    #3;
    check_eq("reset/pulses", 32'({DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_MOVE,
                                  DELAY_LINE_DIRECTION}), 0);
    check_eq("reset/status", 32'({BUSY, DONE, FAIL}), 0);
    check_eq("reset/cur_tap", 32'(CUR_TAP), 0);
    check_eq("reset/edge_tap", 32'(EDGE_TAP), 0);
    repeat (3) @(posedge FAB_CLK);
    #1;
    ARST_N = 1'b1;
    @(posedge FAB_CLK);
    #1;
    check_eq("idle/busy", 32'(BUSY), 0);

    train_and_check("edge10_level", ModeLevel, 10, -1, -1, -1, 5);
    train_and_check("edge2_pulse", ModePulse, 2, -1, -1, -1, -1);
    train_and_check("edge0_level", ModeLevel, 0, -1, -1, -1, 12);
    train_and_check("no_edge", ModeLevel, -1, -1, -1, -1, -1);
    train_and_check("oor_at_50", ModeLevel, -1, -1, 50, -1, -1);
    train_and_check("settle_only_5", ModeSettle, 8, 5, -1, -1, -1);
    train_and_check("abort_in_sample", ModeLevel, 20, -1, -1, 3, -1);
    train_and_check("after_abort", ModePulse, 7, -1, -1, -1, 30);

    for (int i = 0; i < 6; i++) begin
      mode = $urandom_range(ModeSettle, ModeLevel);
      e    = $urandom_range(40, 0);
      fs   = -1;
      if (mode == ModeSettle) begin
        if (e == 0) e = 1;
        fs = $urandom_range(e - 1, 0);
      end
      train_and_check($sformatf("rand%0d_m%0d_e%0d", i, mode, e), mode, e, fs, -1, -1,
                      $urandom_range(20, 2));
    end

    // Asynchronous reset in the middle of a sweep.
    START = 1'b1;
    @(posedge FAB_CLK);
    #1;
    START = 1'b0;
    repeat (60) @(posedge FAB_CLK);
    #3;
    ARST_N = 1'b0;
    #1;
    check_eq("midreset/outputs", 32'({DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS, DELAY_LINE_MOVE,
                                      DELAY_LINE_DIRECTION, BUSY, DONE, FAIL}), 0);
    check_eq("midreset/cur_tap", 32'(CUR_TAP), 0);
    @(posedge FAB_CLK);
    #1;
    ARST_N = 1'b1;
    @(posedge FAB_CLK);
    #1;
    train_and_check("after_reset", ModeLevel, 3, -1, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
